// File: rtl/rc4_pkg.sv
// Shared types and helpers for the decrypted-message checker.
package rc4_pkg;

    localparam int         MSG_LEN = 32;
    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK_DEC,
        S_SEND_ADDR,
        S_WAIT_ADDR,
        S_CHECK_CHAR,
        S_NEXT_KEY,
        S_DONE
    } state_t;

    // Plaintext alphabet: lowercase letters and space.
    function automatic bit is_plain_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
    endfunction

endpackage

// File: rtl/fsm_message_checker_if.sv
// Bundle of the decrypt-engine and controller handshakes seen by the checker.
//
// Handshakes: Decrypt_Finish is a level from the decrypt engine; the checker
// answers with a single-cycle Decrypt_Ack, after which the engine drops Finish.
// Next_Key_Req is a single-cycle pulse asking the engine for a new pass with
// Secret_Key. Check_Finish is a level held until the controller asserts
// Check_Ack; Msg_Valid/Key_Exhausted/Bad_Index are meaningful while it is high.
interface fsm_message_checker_if #(
    parameter int ADDR_W = 5,
    parameter int KEY_W  = 24
);
    logic              Decrypt_Finish;
    logic              Decrypt_Ack;
    logic [7:0]        q_D;
    logic [ADDR_W-1:0] Address_D;
    logic              Next_Key_Req;
    logic [KEY_W-1:0]  Secret_Key;
    logic              Check_Finish;
    logic              Check_Ack;
    logic              Msg_Valid;
    logic              Key_Exhausted;
    logic [ADDR_W-1:0] Bad_Index;

    // Checker side.
    modport master (
        input  Decrypt_Finish, q_D, Check_Ack,
        output Decrypt_Ack, Address_D, Next_Key_Req, Secret_Key,
               Check_Finish, Msg_Valid, Key_Exhausted, Bad_Index
    );

    // Decrypt engine / controller side.
    modport slave (
        output Decrypt_Finish, q_D, Check_Ack,
        input  Decrypt_Ack, Address_D, Next_Key_Req, Secret_Key,
               Check_Finish, Msg_Valid, Key_Exhausted, Bad_Index
    );
endinterface

// File: rtl/fsm_message_checker.sv
// Scans each decrypted message byte by byte; on the first non-plaintext byte
// it steps the candidate key and asks for a new decrypt pass, otherwise it
// reports success (or key-space exhaustion) to the controller.
// ADDR_W must be wide enough to address MSG_LEN bytes.
module fsm_message_checker
    import rc4_pkg::*;
#(
    parameter int               ADDR_W  = 5,
    parameter int               KEY_W   = 24,
    parameter logic [KEY_W-1:0] KEY_MAX = 'h3FFFFF,
    parameter int               MSG_LEN = rc4_pkg::MSG_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    fsm_message_checker_if.master bus,
    output state_t                dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] addr_q;
    logic [KEY_W-1:0]  key_q;
    logic              msg_valid_q;
    logic              key_exh_q;
    logic [ADDR_W-1:0] bad_index_q;
    logic              byte_ok;
    logic              key_at_max;
    logic              last_byte;

    assign byte_ok    = is_plain_char(bus.q_D);
    assign key_at_max = (key_q == KEY_MAX);
    assign last_byte  = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the read path spends three cycles per byte.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:       if (bus.Decrypt_Finish) state_nxt = S_ACK_DEC;
            S_ACK_DEC:    state_nxt = S_SEND_ADDR;
            S_SEND_ADDR:  state_nxt = S_WAIT_ADDR;
            S_WAIT_ADDR:  state_nxt = S_CHECK_CHAR;
            S_CHECK_CHAR: begin
                if (byte_ok) state_nxt = last_byte ? S_DONE : S_SEND_ADDR;
                else         state_nxt = key_at_max ? S_DONE : S_NEXT_KEY;
            end
            S_NEXT_KEY:   state_nxt = S_IDLE;
            S_DONE:       if (bus.Check_Ack) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte index, RAM address, key and registered result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            addr_q      <= '0;
            key_q       <= '0;
            msg_valid_q <= 1'b0;
            key_exh_q   <= 1'b0;
            bad_index_q <= '0;
        end else begin
            unique case (state)
                S_IDLE:      if (bus.Decrypt_Finish) idx <= '0;
                S_SEND_ADDR: addr_q <= idx;
                S_CHECK_CHAR: begin
                    if (byte_ok) begin
                        if (last_byte) msg_valid_q <= 1'b1;
                        else           idx <= idx + 1'b1;
                    end else begin
                        // Early exit: the remaining bytes of this pass are skipped.
                        bad_index_q <= idx;
                        if (key_at_max) key_exh_q <= 1'b1;
                        else            key_q <= key_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.Check_Ack) begin
                        key_q       <= '0;
                        msg_valid_q <= 1'b0;
                        key_exh_q   <= 1'b0;
                        bad_index_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake strobes come straight from the state register (glitch-free).
    assign bus.Decrypt_Ack   = (state == S_ACK_DEC);
    assign bus.Next_Key_Req  = (state == S_NEXT_KEY);
    assign bus.Check_Finish  = (state == S_DONE);
    assign bus.Address_D     = addr_q;
    assign bus.Secret_Key    = key_q;
    assign bus.Msg_Valid     = msg_valid_q;
    assign bus.Key_Exhausted = key_exh_q;
    assign bus.Bad_Index     = bad_index_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_fsm_message_checker.sv
// Directed bench for fsm_message_checker: one instance with the full key
// space and one with KEY_MAX=3 for the exhaustion case.
module tb_fsm_message_checker;
    import rc4_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Clock / reset block.
    always #5 clk = ~clk;

    fsm_message_checker_if #(.ADDR_W(5), .KEY_W(24)) ia ();
    fsm_message_checker_if #(.ADDR_W(5), .KEY_W(24)) ib ();
    state_t st_a;
    state_t st_b;

    fsm_message_checker #(.ADDR_W(5), .KEY_W(24)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.master), .dbg_state(st_a)
    );
    fsm_message_checker #(.ADDR_W(5), .KEY_W(24), .KEY_MAX(24'h3)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.master), .dbg_state(st_b)
    );

    // Decrypted RAM models: 1-cycle read latency; dut_b always sees 'A'.
    logic [7:0] mem_a [32];
    always @(posedge clk) ia.q_D <= mem_a[ia.Address_D];
    always @(posedge clk) ib.q_D <= 8'h41;

    // Monitor on dut_a: pulse counts and highest address actually read.
    logic       mon_clr;
    int         ack_cnt;
    int         nk_cnt;
    logic [4:0] max_addr;
    always @(posedge clk) begin
        if (mon_clr) begin
            ack_cnt  = 0;
            nk_cnt   = 0;
            max_addr = '0;
        end else begin
            if (ia.Decrypt_Ack)  ack_cnt++;
            if (ia.Next_Key_Req) nk_cnt++;
            if (st_a == S_WAIT_ADDR && ia.Address_D > max_addr) max_addr = ia.Address_D;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_a(input logic [7:0] v);
        for (int i = 0; i < 32; i++) mem_a[i] = v;
    endtask

    // Engine driver: raise Finish, drop it after Ack, run until NEXT_KEY (ev=1)
    // or DONE (ev=2); cyc counts cycles starting with the Finish sampling cycle.
    task automatic run_pass(input bit sel_b, output int ev, output int cyc);
        logic ack, nk, cf;
        ev  = 0;
        cyc = 0;
        if (sel_b) ib.Decrypt_Finish = 1'b1; else ia.Decrypt_Finish = 1'b1;
        while (ev == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            ack = sel_b ? ib.Decrypt_Ack  : ia.Decrypt_Ack;
            nk  = sel_b ? ib.Next_Key_Req : ia.Next_Key_Req;
            cf  = sel_b ? ib.Check_Finish : ia.Check_Finish;
            if (ack) begin
                if (sel_b) ib.Decrypt_Finish = 1'b0; else ia.Decrypt_Finish = 1'b0;
            end
            if (nk)      ev = 1;
            else if (cf) ev = 2;
        end
        check("pass_timeout", 32'(ev != 0), 32'd1);
    endtask

    task automatic check_ack(input bit sel_b);
        if (sel_b) ib.Check_Ack = 1'b1; else ia.Check_Ack = 1'b1;
        @(negedge clk);
        if (sel_b) ib.Check_Ack = 1'b0; else ia.Check_Ack = 1'b0;
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_key"}, 32'(ia.Secret_Key), 32'd0);
        check({tag, "_ctl"}, 32'({ia.Decrypt_Ack, ia.Next_Key_Req, ia.Check_Finish,
                                  ia.Msg_Valid, ia.Key_Exhausted, ia.Bad_Index, ia.Address_D}), 32'd0);
    endtask

    task automatic check_zero_b(input string tag);
        check({tag, "_key"}, 32'(ib.Secret_Key), 32'd0);
        check({tag, "_ctl"}, 32'({ib.Decrypt_Ack, ib.Next_Key_Req, ib.Check_Finish,
                                  ib.Msg_Valid, ib.Key_Exhausted, ib.Bad_Index, ib.Address_D}), 32'd0);
    endtask

    initial begin
        int  ev;
        int  cyc;
        bit  found;
        rst               = 1'b1;
        mon_clr           = 1'b1;
        ia.Decrypt_Finish = 1'b0;
        ia.Check_Ack      = 1'b0;
        ib.Decrypt_Finish = 1'b0;
        ib.Check_Ack      = 1'b0;
        fill_a(8'h61);
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_state_a", 32'(st_a), 32'(S_IDLE));
        check_zero_a("rst_a");
        check_zero_b("rst_b");
        rst     = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);

        // Check_Ack in IDLE has no effect.
        check_ack(1'b0);
        check("idle_ack_state", 32'(st_a), 32'(S_IDLE));

        // Full valid pass, key 0.
        clear_mon();
        run_pass(1'b0, ev, cyc);
        check("t1_event", 32'(ev), 32'd2);
        check("t1_latency", 32'(cyc), 32'd98);
        check("t1_ack_pulses", 32'(ack_cnt), 32'd1);
        check("t1_msg_valid", 32'(ia.Msg_Valid), 32'd1);
        check("t1_key_exh", 32'(ia.Key_Exhausted), 32'd0);
        check("t1_key", 32'(ia.Secret_Key), 32'd0);
        check("t1_max_addr", 32'(max_addr), 32'd31);
        check_ack(1'b0);
        check("t1_ackd_state", 32'(st_a), 32'(S_IDLE));
        check("t1_ackd_flags", 32'({ia.Check_Finish, ia.Msg_Valid}), 32'd0);

        // Bad byte at index 5: early exit and key step.
        mem_a[5] = 8'h41;
        clear_mon();
        run_pass(1'b0, ev, cyc);
        check("t2_event", 32'(ev), 32'd1);
        check("t2_bad_index", 32'(ia.Bad_Index), 32'd5);
        check("t2_key", 32'(ia.Secret_Key), 32'd1);
        check("t2_max_addr", 32'(max_addr), 32'd5);
        @(negedge clk);
        check("t2_nk_pulses", 32'(nk_cnt), 32'd1);
        check("t2_idle", 32'(st_a), 32'(S_IDLE));
        check("t2_nk_low", 32'(ia.Next_Key_Req), 32'd0);

        // Boundary characters.
        do_reset();
        for (int i = 0; i < 32; i++) mem_a[i] = (i % 3 == 0) ? 8'h20 : ((i % 3 == 1) ? 8'h7A : 8'h61);
        run_pass(1'b0, ev, cyc);
        check("t3_edges_event", 32'(ev), 32'd2);
        check("t3_edges_valid", 32'(ia.Msg_Valid), 32'd1);
        check_ack(1'b0);
        mem_a[0] = 8'h60;
        run_pass(1'b0, ev, cyc);
        check("t3_60_event", 32'(ev), 32'd1);
        check("t3_60_bad_index", 32'(ia.Bad_Index), 32'd0);
        check("t3_60_key", 32'(ia.Secret_Key), 32'd1);
        do_reset();
        mem_a[0]  = 8'h20;
        mem_a[31] = 8'h7B;
        run_pass(1'b0, ev, cyc);
        check("t3_7b_event", 32'(ev), 32'd1);
        check("t3_7b_bad_index", 32'(ia.Bad_Index), 32'd31);
        check("t3_7b_msg_valid", 32'(ia.Msg_Valid), 32'd0);

        // Key search: keys 0..2 fail at byte k, key 3 decrypts cleanly.
        do_reset();
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            fill_a(8'h7A);
            if (k < 3) mem_a[k] = 8'h7B;
            run_pass(1'b0, ev, cyc);
            if (k < 3) begin
                check("t4_fail_event", 32'(ev), 32'd1);
                check("t4_fail_key", 32'(ia.Secret_Key), 32'(k + 1));
                check("t4_fail_bad_index", 32'(ia.Bad_Index), 32'(k));
            end else begin
                check("t4_hit_event", 32'(ev), 32'd2);
            end
        end
        check("t4_nk_pulses", 32'(nk_cnt), 32'd3);
        check("t4_msg_valid", 32'(ia.Msg_Valid), 32'd1);
        check("t4_key", 32'(ia.Secret_Key), 32'd3);
        check_ack(1'b0);

        // Exhaustion on the KEY_MAX=3 instance.
        for (int p = 0; p < 4; p++) begin
            run_pass(1'b1, ev, cyc);
            if (p < 3) begin
                check("t5_fail_event", 32'(ev), 32'd1);
                check("t5_fail_key", 32'(ib.Secret_Key), 32'(p + 1));
            end else begin
                check("t5_done_event", 32'(ev), 32'd2);
            end
        end
        check("t5_key_exh", 32'(ib.Key_Exhausted), 32'd1);
        check("t5_msg_valid", 32'(ib.Msg_Valid), 32'd0);
        check("t5_key", 32'(ib.Secret_Key), 32'd3);
        check("t5_check_finish", 32'(ib.Check_Finish), 32'd1);
        check_ack(1'b1);
        check_zero_b("t5_ackd");

        // Reset in WAIT_ADDR at idx 10 after the key has moved.
        do_reset();
        fill_a(8'h61);
        mem_a[0] = 8'h41;
        run_pass(1'b0, ev, cyc);
        check("t6_pre_key", 32'(ia.Secret_Key), 32'd1);
        fill_a(8'h61);
        @(negedge clk);
        ia.Decrypt_Finish = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (ia.Decrypt_Ack) ia.Decrypt_Finish = 1'b0;
            if (st_a == S_WAIT_ADDR && ia.Address_D == 5'd10) found = 1'b1;
        end
        check("t6_reach_idx10", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_state", 32'(st_a), 32'(S_IDLE));
        check_zero_a("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ia.Decrypt_Finish = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (ia.Decrypt_Ack) ia.Decrypt_Finish = 1'b0;
            if (st_a == S_WAIT_ADDR) found = 1'b1;
        end
        check("t6_restart_seen", 32'(found), 32'd1);
        check("t6_restart_addr", 32'(ia.Address_D), 32'd0);

        // Final report.
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
